// File: rtl/sim_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sim_sram_pkg
//  Description : Shared types and helpers for the simulation SRAM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package sim_sram_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} sram_arb_state_e;

    // An address below the base must be caught here, because the
    // relocated offset wraps modulo 2^ADDR_W and would look in range.
    function automatic logic addr_oob(
        input logic [31:0] addr,
        input logic [31:0] start,
        input logic [31:0] depth
    );
        return (addr < start) || ((addr - start) >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_sram_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick, searching upward from ptr.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_SUM_W = c_IDX_W + 1;

    logic [c_SUM_W-1:0] w_sum;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit holds ptr+k so the modulo wrap is a single subtract.
            w_sum = {1'b0, ptr} + c_SUM_W'(k);
            if (w_sum >= c_SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - c_SUM_W'(NUM_REQ);
            end
            w_idx = w_sum[c_IDX_W-1:0];
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sim_sram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sim_sram_arb
//  Description : Round-robin sequencer sharing one single-port sim SRAM.
//  Revision    : 1.0  initial release
// ============================================================================
module sim_sram_arb
    import sim_sram_pkg::*;
#(
    parameter int                NUM_REQ    = 2,
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 256,
    parameter logic [ADDR_W-1:0] START_ADDR = 16'h0001
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       sram_en,
    output logic                       sram_we,
    output logic [$clog2(DEPTH)-1:0]   sram_addr,
    output logic [DATA_W-1:0]          sram_wdata,
    input  logic [DATA_W-1:0]          sram_rdata
);

    localparam int         c_IDX_W     = $clog2(NUM_REQ);
    localparam int         c_SA_W      = $clog2(DEPTH);
    localparam logic [1:0] c_ST_IDLE   = IDLE;
    localparam logic [1:0] c_ST_ACCESS = ACCESS;
    localparam logic [1:0] c_ST_RESP   = RESP;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_owner;
    logic               r_we;
    logic               r_oob;
    logic [c_SA_W-1:0]  r_off;
    logic [DATA_W-1:0]  r_wdata;

    logic [NUM_REQ-1:0] w_gnt;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic               w_idle;
    logic               w_hs;
    logic [ADDR_W-1:0]  w_addr;
    logic [c_SA_W-1:0]  w_off;
    logic               w_oob;
    logic               w_access_en;
    logic               w_resp;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_idle    = (r_state == c_ST_IDLE);
    assign req_ready = w_idle ? w_gnt : '0;
    assign w_hs      = w_idle && (|req_valid);

    assign w_addr = req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
    // Only the low offset bits reach the SRAM; the full compare lives in addr_oob.
    assign w_off  = w_addr[c_SA_W-1:0] - START_ADDR[c_SA_W-1:0];
    assign w_oob  = addr_oob(32'(w_addr), 32'(START_ADDR), 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_we     <= 1'b0;
            r_oob    <= 1'b0;
            r_off    <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_hs) begin
                        r_owner  <= w_gnt_idx;
                        r_we     <= req_we[w_gnt_idx];
                        r_wdata  <= req_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
                        r_off    <= w_off;
                        r_oob    <= w_oob;
                        r_rr_ptr <= (w_gnt_idx == c_IDX_W'(NUM_REQ - 1)) ?
                                    '0 : w_gnt_idx + c_IDX_W'(1);
                        r_state  <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: r_state <= c_ST_RESP;
                c_ST_RESP:   r_state <= c_ST_IDLE;
                default:     r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Idle-state outputs are forced to zero so waveforms stay readable.
    assign w_access_en = (r_state == c_ST_ACCESS) && !r_oob;
    assign sram_en     = w_access_en;
    assign sram_we     = w_access_en && r_we;
    assign sram_addr   = w_access_en ? r_off   : '0;
    assign sram_wdata  = w_access_en ? r_wdata : '0;

    assign w_resp    = (r_state == c_ST_RESP);
    assign rsp_err   = w_resp && r_oob;
    assign rsp_rdata = (w_resp && !r_oob && !r_we) ? sram_rdata : '0;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
            assign rsp_valid[i] = w_resp && (r_owner == c_IDX_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sim_sram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_sram_arb
//  Description : Randomised bench for sim_sram_arb with a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sim_sram_arb;

    localparam int          NREQ  = 2;
    localparam int          AW    = 16;
    localparam int          DW    = 32;
    localparam int          DEPTH = 256;
    localparam int unsigned START = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 sram_en;
    logic                 sram_we;
    logic [7:0]           sram_addr;
    logic [DW-1:0]        sram_wdata;
    bit   [DW-1:0]        sram_rdata;
    bit   [DW-1:0]        sram_mem [DEPTH];
    bit   [DW-1:0]        ref_mem  [DEPTH];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int hs_cnt [NREQ];

    sim_sram_arb #(
        .NUM_REQ    (NREQ),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .DEPTH      (DEPTH),
        .START_ADDR (16'h0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port SRAM: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: 'age' counts cycles since the last handshake.
    initial begin : ref_model
        int age, ptr, owner, off, g, idx;
        bit we, oob;
        logic [DW-1:0] wd, erd;
        int unsigned a;
        logic [NREQ-1:0] er, ev;
        age = 3; ptr = 0; owner = 0; off = 0; we = 0; oob = 0; wd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (age == 1 && !oob && we) ref_mem[off] = wd;
                age = 3;
                ptr = 0;
            end else begin
                g = -1;
                if (age >= 3) begin
                    for (int k = 0; k < NREQ; k++) begin
                        idx = (ptr + k) % NREQ;
                        if (g < 0 && req_valid[idx]) g = idx;
                    end
                end
                er = '0;
                if (g >= 0) er[g] = 1'b1;
                check_eq("req_ready", req_ready, er);
                if (age == 1 && !oob) begin
                    check_eq("sram_en", sram_en, 1);
                    check_eq("sram_we", sram_we, we);
                    check_eq("sram_addr", sram_addr, off);
                    check_eq("sram_wdata", sram_wdata, wd);
                    if (we) ref_mem[off] = wd;
                end else begin
                    check_eq("sram_en", sram_en, 0);
                    check_eq("sram_we", sram_we, 0);
                    check_eq("sram_addr", sram_addr, 0);
                    check_eq("sram_wdata", sram_wdata, 0);
                end
                ev = '0;
                erd = '0;
                if (age == 2) begin
                    ev[owner] = 1'b1;
                    erd = (!oob && !we) ? ref_mem[off] : '0;
                end
                check_eq("rsp_valid", rsp_valid, ev);
                check_eq("rsp_err", rsp_err, (age == 2) && oob);
                check_eq("rsp_rdata", rsp_rdata, erd);
                if (g >= 0) begin
                    a     = req_addr[g*AW +: AW];
                    owner = g;
                    we    = req_we[g];
                    wd    = req_wdata[g*DW +: DW];
                    oob   = (a < START) || ((a - START) >= DEPTH);
                    off   = int'((a - START) % DEPTH);
                    ptr   = (g + 1) % NREQ;
                    age   = 1;
                end else if (age < 3) begin
                    age++;
                end
            end
        end
    end

    task automatic new_payload(input int i);
        int sel;
        logic [AW-1:0] a;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: a = 16'($urandom_range(1, 16));
            3, 4, 5: a = 16'($urandom_range(1, 256));
            6:       a = 16'h0000;
            7:       a = 16'($urandom_range(257, 16'hFFFF));
            8:       a = 16'h0100;
            default: a = 16'h0101;
        endcase
        req_we[i]              = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = $urandom;
        req_valid[i]           = 1'b1;
    endtask

    task automatic single(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 0;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]          = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = req_valid[i] && req_ready[i];
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        if (!got) check_eq("single_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NREQ-1:0] mask, input int pct, input int target,
                         input int max_cyc, input bit chk_alt);
        int done, last_hs, hs_cyc;
        logic [NREQ-1:0] hs;
        done = 0;
        last_hs = -1;
        for (int i = 0; i < NREQ; i++) hs_cnt[i] = 0;
        for (int c = 0; c < max_cyc && done < target; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            hs_cyc = cyc;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    if (chk_alt) begin
                        check_eq("rr_order", i, done % 2);
                        if (last_hs >= 0) check_eq("hs_spacing", hs_cyc - last_hs, 3);
                    end
                    last_hs = hs_cyc;
                    done++;
                    hs_cnt[i]++;
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && mask[i] && done < target && $urandom_range(0, 99) < pct)
                    new_payload(i);
            end
        end
        req_valid = '0;
        if (done < target) check_eq("drive_timeout", done, target);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : stim
        bit got;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        single(0, 1'b1, 16'h0011, 32'hDEADBEEF);
        single(0, 1'b0, 16'h0011, 32'h0);
        single(0, 1'b0, 16'h0000, 32'h0);
        single(0, 1'b0, 16'h0101, 32'h0);
        single(1, 1'b1, 16'h0100, 32'hA5C3_0F1E);
        single(1, 1'b0, 16'h0100, 32'h0);

        // Contention straight out of reset
        pulse_reset();
        drive(2'b11, 100, 8, 100, 1'b1);
        check_eq("cont_cnt0", hs_cnt[0], 4);
        check_eq("cont_cnt1", hs_cnt[1], 4);

        // Reset while an access is in flight
        got = 0;
        req_we[0] = 1'b0;
        req_addr[0 +: AW] = 16'h0020;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = req_valid[0] && req_ready[0];
            @(posedge clk); #1;
        end
        if (!got) check_eq("rst_hs_timeout", 0, 1);
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_we = '0;
        req_addr = {16'h0030, 16'h0031};
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("rst_ptr_gnt", req_ready, 2'b01);
        check_eq("rst_no_rsp", rsp_valid, 2'b00);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Lone requester keeps winning
        drive(2'b10, 100, 3, 100, 1'b0);
        check_eq("fair_cnt0", hs_cnt[0], 0);
        check_eq("fair_cnt1", hs_cnt[1], 3);

        drive(2'b11, 40, 150, 3000, 1'b0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sim_sram_arb.md
Name: sim_sram_arb

Overview:
- Round-robin arbiter and sequencer that shares one single-port simulation SRAM among NUM_REQ requesters.
- Relocates each request address by the START_ADDR parameter and range-checks it against DEPTH.
- Drives the SRAM's enable, write-enable, address and write-data, and returns read data or an error flag to the requester that issued the access.
- Sits between requester-side sim_sram_if instances and the SRAM model; exactly one access is in flight at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 16, requester address width.
- DATA_W, 32, data width.
- DEPTH, 256, SRAM words, power of two.
- START_ADDR, 16'h0001, requester address that maps to SRAM word 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle response pulse, one-hot.
- rsp_rdata  out  DATA_W  read data, shared across requesters.
- rsp_err  out  1  address out of range; qualified by rsp_valid.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  $clog2(DEPTH)  SRAM word address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - state = IDLE, rr_ptr = 0.
  - All outputs 0, including rsp_rdata and sram_addr.
  - Any in-flight transaction is dropped; no response is ever issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready is combinational and set only for the granted index, only in IDLE.
  - Handshake completes when req_valid & req_ready are both 1.
  - On handshake, register: owner index, we, wdata, off = req_addr - START_ADDR (ADDR_W-bit), and oob.
  - oob = (req_addr < START_ADDR) or (off >= DEPTH).
  - Set rr_ptr = (owner + 1) mod NUM_REQ, then go to ACCESS.
  - With no valid requests, stay in IDLE and leave rr_ptr unchanged.
- ACCESS (one cycle):
  - If !oob: sram_en=1, sram_we=we, sram_addr=off[$clog2(DEPTH)-1:0], sram_wdata=wdata.
  - If oob: sram_en=0.
  - Go to RESP.
- RESP (one cycle):
  - rsp_valid[owner]=1 and rsp_err=oob.
  - rsp_rdata = sram_rdata for an in-range read; otherwise 0.
  - Go to IDLE.
  - The response has no backpressure; requesters must accept it.
- Timing:
  - Handshake in cycle N, sram_en in cycle N+1, rsp_valid in cycle N+2.
  - Next possible handshake is cycle N+3, so peak throughput is one access per 3 cycles.
- Outputs outside their active state:
  - sram_en, sram_we and rsp_valid are 0.
  - sram_addr, sram_wdata and rsp_rdata are driven 0, which keeps waveforms clean.
- Requester obligations: a requester holds req_valid and its payload stable until ready. Deasserting before grant is legal; the request is simply not granted.
- Simultaneous requests are resolved purely by rr_ptr. A lone requester is granted every round.
- Address wrap: the subtraction is modulo 2^ADDR_W. The explicit req_addr < START_ADDR compare, not the wrapped offset, determines oob for low addresses.

Decomposition:
- Package sim_sram_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} sram_arb_state_e;
  - a function computing oob from (addr, start, depth).
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req, ptr.
  - Outputs: one-hot gnt and its binary index.
  - Purely combinational.

Test Plan:
- Single write then read (NUM_REQ=2): req0 writes addr 16'h0011, data 32'hDEADBEEF; later reads 16'h0011.
  -> sram_addr=8'h10 on the write; read response has rsp_valid[0]=1, rsp_rdata=32'hDEADBEEF, rsp_err=0, two cycles after its handshake.
- Contention: req0 and req1 both hold valid continuously, 4 accesses each, after reset.
  -> grant order 0,1,0,1,...; handshakes spaced exactly 3 cycles apart.
- Out of range: read addr 16'h0000 (below START_ADDR), then read 16'h0101 (off=256).
  -> sram_en stays 0; rsp_err=1; rsp_rdata=0.
- Boundary: write/read addr 16'h0100 (off=255).
  -> sram_addr=8'hFF, rsp_err=0, data round-trips.
- Reset mid-operation: assert rst in ACCESS.
  -> next cycle all outputs 0, no rsp_valid pulse, rr_ptr=0, so req1 and req0 both valid grants req0.
- Idle fairness: only req1 valid for 3 requests.
  -> req1 granted each time, 3 responses to req1, none to req0.
